// File: rtl/control_unit.sv
// Multicycle MIPS main control FSM with ALU decoder. Moore outputs decode from the
// registered state; PC_enable also folds in the ALU zero flag during BRANCH.
module control_unit #(
    parameter int STATE_WIDTH  = 4,
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             op,
    input  logic [5:0]             Funct,
    input  logic                   zero,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [2:0]             ALUControl,
    output logic                   PC_enable,
    output logic                   IorD,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   RegDst,
    output logic                   MemtoReg,
    output logic                   RegWrite,
    output logic                   PCSrc,
    output logic [STATE_WIDTH-1:0] state_o,
    output logic                   illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXEC     = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    state_t     r_state;
    state_t     w_next;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_irwrite;
    logic       w_memwrite;
    logic       w_regwrite;
    logic       w_illegal;
    logic       w_funct_ok;
    logic [2:0] w_funct_alu;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = 3'b010;
        case (Funct)
            6'h20:   w_funct_alu = 3'b010;
            6'h22:   w_funct_alu = 3'b110;
            6'h24:   w_funct_alu = 3'b000;
            6'h25:   w_funct_alu = 3'b001;
            6'h2A:   w_funct_alu = 3'b111;
            default: w_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_illegal  = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b010;
        IorD       = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        PCSrc      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                ALUSrcB   = 2'b01;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                if (op == OP_LW || op == OP_SW)        w_next = S_MEMADR;
                else if (op == OP_RTYPE && w_funct_ok) w_next = S_EXEC;
                else if (op == OP_BEQ)                 w_next = S_BRANCH;
                else if (op == OP_ADDI)                w_next = S_ADDIEXEC;
                else begin
                    w_illegal = 1'b1;
                    w_next    = ILLEGAL_TRAP ? S_HALT : S_FETCH;
                end
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD   = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                MemtoReg   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                IorD       = 1'b1;
                w_memwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUControl = w_funct_alu;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                RegDst     = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = 3'b110;
                PCSrc      = 1'b1;
                w_branch   = 1'b1;
                w_next     = S_FETCH;
            end
            S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // Write/load enables are gated by reset so nothing commits while it is held low.
    assign PC_enable  = reset & (w_pcwrite | (w_branch & zero));
    assign IRWrite    = reset & w_irwrite;
    assign MemWrite   = reset & w_memwrite;
    assign RegWrite   = reset & w_regwrite;
    assign illegal_op = reset & w_illegal;
    assign state_o    = STATE_WIDTH'(r_state);

endmodule
